// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC and drives a req/ack imem port. FETCH_PERF_CNT_EN adds perf counters.
// Latency: zero-wait memory presents one instruction per cycle, combinationally in the ack cycle.
// Backpressure: freeze parks the acked word in HOLD; fetch_stall flags cycles with no valid instruction.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] instruction,
  output logic        fetch_stall,
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_stalls
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_reg, pc_nxt;
  logic [31:0] drain_addr, drain_nxt;
  logic [31:0] inst_buf, buf_nxt;
  logic [31:0] pc_inc;

  assign pc_inc = pc_reg + PC_INC;
  assign PC     = pc_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc_reg     <= RESET_PC;
      drain_addr <= '0;
      inst_buf   <= '0;
    end else begin
      state      <= state_nxt;
      pc_reg     <= pc_nxt;
      drain_addr <= drain_nxt;
      inst_buf   <= buf_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc_reg;
    drain_nxt   = drain_addr;
    buf_nxt     = inst_buf;
    imem_req    = 1'b0;
    imem_addr   = pc_reg;
    instruction = '0;
    fetch_stall = 1'b1;
    case (state)
      FETCH: begin
        imem_req    = 1'b1;
        fetch_stall = ~imem_ack;
        if (imem_ack) instruction = imem_rdata;
        if (branch_taken && imem_ack) begin
          pc_nxt = branch_addr;
        end else if (branch_taken) begin
          // The outstanding request must complete at its original address.
          drain_nxt = pc_reg;
          pc_nxt    = branch_addr;
          state_nxt = DRAIN;
        end else if (imem_ack && !freeze) begin
          pc_nxt = pc_inc;
        end else if (imem_ack) begin
          buf_nxt   = imem_rdata;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        instruction = inst_buf;
        fetch_stall = 1'b0;
        if (branch_taken) begin
          pc_nxt    = branch_addr;
          state_nxt = FETCH;
        end else if (!freeze) begin
          pc_nxt    = pc_inc;
          state_nxt = FETCH;
        end
      end
      DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr;
        if (branch_taken) pc_nxt = branch_addr;
        if (imem_ack) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic fetch_acc;
  logic [31:0] fetch_cnt, stall_cnt;

  assign fetch_acc = ~branch_taken & ~freeze &
                     (((state == FETCH) & imem_ack) | (state == HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (fetch_acc)   fetch_cnt <= fetch_cnt + 32'd1;
      if (fetch_stall) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_fetches = fetch_cnt;
  assign perf_stalls  = stall_cnt;
`else
  assign perf_fetches = '0;
  assign perf_stalls  = '0;
`endif

endmodule
